// File: rtl/fomux_rr_arbiter.sv
// Round-robin arbiter owning a shared 4:1 mux, with a bounded hold time.
// Grant, select and valid are registered; dout is the live mux output.
module fomux_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] din,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       valid,
    output logic       dout
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     gnt_q, gnt_d;
    logic [1:0]     sel_q, sel_d;
    logic [1:0]     last_q, last_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           own;
    logic [3:0]     cand;
    logic [1:0]     win;

    // First set bit scanning base+1, base+2, base+3, base.
    function automatic logic [1:0] rr_pick(
        input logic [3:0] r,
        input logic [1:0] base
    );
        logic [1:0] idx;
        rr_pick = base;
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        own     = req[sel_q];
        cand    = req;
        win     = 2'd0;

        unique case (state_q)
            IDLE: begin
                cand = req;
            end
            GRANT: begin
                if (own && (cnt_q < CW'(MAX_HOLD))) begin
                    cand  = 4'b0000;
                end else if (own) begin
                    cand  = req;
                end else begin
                    cand  = req & ~(4'b0001 << sel_q);
                end
            end
            default: begin
                cand = 4'b0000;
            end
        endcase

        win = rr_pick(cand, last_q);

        if (state_q == GRANT && own && (cnt_q < CW'(MAX_HOLD))) begin
            cnt_d = cnt_q + CW'(1);
        end else if (|cand) begin
            state_d = GRANT;
            gnt_d   = 4'b0001 << win;
            sel_d   = win;
            last_d  = win;
            cnt_d   = CW'(1);
        end else begin
            // Release with nobody waiting, or idle with no requests.
            state_d = IDLE;
            gnt_d   = 4'b0000;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = (state_q == GRANT);
    assign dout  = valid & din[sel_q];

endmodule

// File: tb/tb_fomux_rr_arbiter.sv
// Bench for fomux_rr_arbiter: two instances (hold limit 4 and 1) checked
// every cycle against a behavioural model, plus directed literal checks.
module tb_fomux_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] din = 4'b0000;

    logic [3:0] gnt4, gnt1;
    logic [1:0] sel4, sel1;
    logic       valid4, valid1, dout4, dout1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fomux_rr_arbiter #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din),
        .gnt(gnt4), .sel(sel4), .valid(valid4), .dout(dout4)
    );

    fomux_rr_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din),
        .gnt(gnt1), .sel(sel1), .valid(valid1), .dout(dout1)
    );

    // Behavioural model: who owns the mux, for how long, and who went last.
    int  lim [2] = '{4, 1};
    int  m_busy [2];
    int  m_hold [2];
    int  m_last [2];
    int  m_cnt  [2];
    bit  model_ok = 1'b0;

    function automatic int rr(input int r, input int last);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (last + k) % 4;
            if (((r >> i) & 1) != 0) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int r, w, c;
        r = int'(req);
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                m_busy[m] = 0; m_hold[m] = 0;
                m_last[m] = 3; m_cnt[m] = 0;
            end else begin
                w = -1;
                if (m_busy[m] == 0) begin
                    w = rr(r, m_last[m]);
                end else if (((r >> m_hold[m]) & 1) != 0 && m_cnt[m] < lim[m]) begin
                    m_cnt[m] = m_cnt[m] + 1;
                    continue;
                end else begin
                    c = (((r >> m_hold[m]) & 1) != 0) ? r : (r & ~(1 << m_hold[m]));
                    w = rr(c, m_last[m]);
                end
                if (w >= 0) begin
                    m_busy[m] = 1; m_hold[m] = w;
                    m_last[m] = w; m_cnt[m] = 1;
                end else begin
                    m_busy[m] = 0; m_cnt[m] = 0;
                end
            end
        end
        if (!rst_n) model_ok = 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            chk("gnt4", gnt4, m_busy[0] != 0 ? (1 << m_hold[0]) : 0);
            chk("sel4", sel4, m_hold[0]);
            chk("valid4", valid4, m_busy[0]);
            chk("dout4", dout4, m_busy[0] != 0 ? din[m_hold[0]] : 0);
            chk("gnt1", gnt1, m_busy[1] != 0 ? (1 << m_hold[1]) : 0);
            chk("sel1", sel1, m_hold[1]);
            chk("valid1", valid1, m_busy[1]);
            chk("dout1", dout1, m_busy[1] != 0 ? din[m_hold[1]] : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        req = 4'b0000;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_gnt", gnt4, 0);
        chk("rst_valid", valid4, 0);
        chk("rst_sel", sel4, 0);

        // All requesting: blocks of four on hold 4, every cycle on hold 1.
        req = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("rot4", gnt4, 1 << (i / 4));
            chk("rot1", gnt1, 1 << (i % 4));
        end

        req = 4'b0000;
        tick();
        tick();
        req = 4'b0100;
        tick();
        chk("pulse_gnt", gnt4, 4'b0100);
        chk("pulse_sel", sel4, 2);
        req = 4'b0000;
        tick();
        chk("pulse_off", valid4, 0);

        req = 4'b0010;
        tick();
        chk("h1_gnt", gnt4, 4'b0010);
        req = 4'b1010;
        tick();
        req = 4'b1000;
        tick();
        chk("handoff_gnt", gnt4, 4'b1000);
        chk("handoff_valid", valid4, 1);

        req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("solo_gnt", gnt4, 4'b0100);
        end

        rst_n = 1'b0;
        req = 4'b1111;
        tick();
        chk("midrst_gnt", gnt4, 0);
        chk("midrst_dout", dout4, 0);
        rst_n = 1'b1;
        tick();
        chk("postrst_gnt", gnt4, 4'b0001);

        req = 4'b0010;
        tick();
        for (int i = 0; i < 4; i++) begin
            din = 4'b0010;
            #1 chk("dout_hi", dout4, 1);
            tick();
            din = 4'b0000;
            #1 chk("dout_lo", dout4, 0);
            tick();
        end
        req = 4'b0000;
        tick();
        din = 4'b1111;
        #1 chk("dout_idle", dout4, 0);

        for (int i = 0; i < 3000; i++) begin
            tick();
            rst_n = ($urandom_range(63) != 0);
            if ($urandom_range(3) == 0) req = 4'($urandom);
            else if ($urandom_range(1) == 0) req = req ^ (4'b0001 << $urandom_range(3));
            din = 4'($urandom);
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
